awg_key_ctrl: RTL

//  Front-panel parameter controller placed directly upstream of the signal generator.

---
 rtl/awg_key_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/awg_key_ctrl.sv
// awg_key_ctrl: front-panel parameter controller for the signal generator.
// Debounces four raw push-keys, generates step events (with press-and-hold
// auto-repeat for up/dn), and runs the WAVE/FREQ/AMP/PHASE field editor.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   key_sel/key_up/key_dn/key_run    raw active-high keys
//   state        [4:0]   waveform code (0 saw, 1 tri, 2 sqr, 3 sin, 10 off)
//   state_freq   [11:0]  frequency word
//   state_amp    [7:0]   amplitude word
//   state_phase  [7:0]   phase word
//   field        [1:0]   field being edited (0 WAVE, 1 FREQ, 2 AMP, 3 PHASE)
//   upd                  one-cycle pulse when state/freq/amp/phase changes
module awg_key_ctrl #(
  parameter logic [19:0] DEB_CYC   = 20'd500000,
  parameter logic [23:0] HOLD_CYC  = 24'd5000000,
  parameter logic [23:0] REP_CYC   = 24'd1000000,
  parameter logic [11:0] FREQ_STEP = 12'd1,
  parameter logic [11:0] FREQ_MIN  = 12'd1,
  parameter logic [11:0] FREQ_MAX  = 12'd4095,
  parameter logic [11:0] FREQ_DEF  = 12'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_sel,
  input  logic        key_up,
  input  logic        key_dn,
  input  logic        key_run,
  output logic [4:0]  state,
  output logic [11:0] state_freq,
  output logic [7:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  field,
  output logic        upd
);

  localparam int unsigned NKEY  = 4;
  localparam int unsigned K_SEL = 0;
  localparam int unsigned K_UP  = 1;
  localparam int unsigned K_DN  = 2;
  localparam int unsigned K_RUN = 3;

  localparam logic [4:0] ST_OFF  = 5'd10;

  localparam logic [1:0] F_WAVE  = 2'd0;
  localparam logic [1:0] F_FREQ  = 2'd1;
  localparam logic [1:0] F_AMP   = 2'd2;
  localparam logic [1:0] F_PHASE = 2'd3;

  logic [NKEY-1:0] key_raw, sync1, sync2;
  logic [NKEY-1:0] deb, deb_q, blk, rise;
  logic [19:0]     deb_cnt [NKEY];
  logic [23:0]     hold_cnt [2];
  logic [1:0]      rep, rep_fire;
  logic            ev_sel, ev_up, ev_dn, ev_run;

  logic [4:0]  state_n;
  logic [11:0] freq_n;
  logic [7:0]  amp_n, phase_n;
  logic [1:0]  field_n, prev_wave, prev_n, wave_n;
  logic [12:0] freq_up13, freq_dn13;
  logic        upd_n;

  assign key_raw = {key_run, key_dn, key_up, key_sel};

  // Two-flop synchroniser; left unreset so a key held through reset stays visible.
  always_ff @(posedge clk) begin
    sync1 <= key_raw;
    sync2 <= sync1;
  end

  // Per-key debounce. After reset each key is blocked until it has been seen
  // released for DEB_CYC cycles, so a key held through reset needs a re-press.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= '0;
      deb_q <= '0;
      blk   <= '1;
      for (int i = 0; i < NKEY; i++) deb_cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < NKEY; i++) begin
        if (blk[i]) begin
          if (sync2[i]) begin
            deb_cnt[i] <= '0;
          end else if (deb_cnt[i] == DEB_CYC - 20'd1) begin
            blk[i]     <= 1'b0;
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 20'd1;
          end
        end else if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_CYC - 20'd1) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 20'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

  // Auto-repeat for up (0) and dn (1): hold_cnt equals cycles held since the
  // debounced rise; first repeat at HOLD_CYC, then every REP_CYC.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 2; i++) begin
      rep_fire[i] = deb[K_UP+i] &&
                    (rep[i] ? (hold_cnt[i] == REP_CYC - 24'd1) : (hold_cnt[i] == HOLD_CYC));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep <= '0;
      for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!deb[K_UP+i]) begin
          rep[i]      <= 1'b0;
          hold_cnt[i] <= '0;
        end else if (rep_fire[i]) begin
          rep[i]      <= 1'b1;
          hold_cnt[i] <= '0;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 24'd1;
        end
      end
    end
  end

  assign ev_sel = rise[K_SEL];
  assign ev_up  = rise[K_UP] | rep_fire[0];
  assign ev_dn  = rise[K_DN] | rep_fire[1];
  assign ev_run = rise[K_RUN];

  // Field FSM and parameter update; up/dn act on the field before any advance.
  always_comb begin
    field_n   = field;
    state_n   = state;
    freq_n    = state_freq;
    amp_n     = state_amp;
    phase_n   = state_phase;
    prev_n    = prev_wave;
    wave_n    = ev_up ? state[1:0] + 2'd1 : state[1:0] - 2'd1;
    freq_up13 = {1'b0, state_freq} + {1'b0, FREQ_STEP};
    freq_dn13 = {1'b0, state_freq} - {1'b0, FREQ_STEP};

    if (ev_sel) begin
      case (field)
        F_WAVE:  field_n = F_FREQ;
        F_FREQ:  field_n = F_AMP;
        F_AMP:   field_n = F_PHASE;
        default: field_n = F_WAVE;
      endcase
    end

    if (ev_run) begin
      if (state == ST_OFF) begin
        state_n = {3'b000, prev_wave};
      end else if (state < 5'd4) begin
        prev_n  = state[1:0];
        state_n = ST_OFF;
      end
    end else if (ev_up != ev_dn) begin
      case (field)
        F_WAVE: begin
          if (state != ST_OFF) state_n = {3'b000, wave_n};
        end
        F_FREQ: begin
          if (ev_up)
            freq_n = (freq_up13 > {1'b0, FREQ_MAX}) ? FREQ_MAX : freq_up13[11:0];
          else
            freq_n = (freq_dn13[12] || freq_dn13[11:0] < FREQ_MIN) ? FREQ_MIN : freq_dn13[11:0];
        end
        F_AMP: begin
          if (ev_up && state_amp != 8'hFF) amp_n = state_amp + 8'd1;
          if (ev_dn && state_amp != 8'h00) amp_n = state_amp - 8'd1;
        end
        default: begin
          phase_n = ev_up ? state_phase + 8'd1 : state_phase - 8'd1;
        end
      endcase
    end

    upd_n = (state_n != state) || (freq_n != state_freq) ||
            (amp_n != state_amp) || (phase_n != state_phase);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      field       <= F_WAVE;
      state       <= 5'd0;
      state_freq  <= FREQ_DEF;
      state_amp   <= 8'hFF;
      state_phase <= 8'd0;
      prev_wave   <= 2'd0;
      upd         <= 1'b0;
    end else begin
      field       <= field_n;
      state       <= state_n;
      state_freq  <= freq_n;
      state_amp   <= amp_n;
      state_phase <= phase_n;
      prev_wave   <= prev_n;
      upd         <= upd_n;
    end
  end

endmodule
